process_scheduler: RTL and testbench

Round-robin multiprogramming scheduler for the processor datapath. It holds a table of process slots (saved PC plus valid bit) and counts retired instructions against a programmable quantum. On expiry or process halt it requests a context switch, saves the preempted PC and selects the next valid slot. It then tells the datapath which PC to load. It sits between the control unit and the datapath's program counter, taking over the quantum and context-switch bookkeeping.

---
 rtl/process_scheduler_if.sv | 38 +++
 rtl/process_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_process_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/process_scheduler_if.sv
// Handshake and configuration bundle between the control unit, datapath PC
// logic and the round-robin process scheduler.
interface process_scheduler_if #(
    parameter int NPROC  = 4,
    parameter int ADDR_W = 12,
    parameter int QW     = 32
);
    localparam int ID_W = $clog2(NPROC);

    logic              cfg_we;
    logic              cfg_sel;
    logic [QW-1:0]     cfg_data;
    logic              proc_load;
    logic [ID_W-1:0]   proc_id;
    logic [ADDR_W-1:0] proc_pc;
    logic              tick;
    logic              proc_kill;
    logic [ADDR_W-1:0] cur_pc;
    logic              cs_ack;
    logic              cs_req;
    logic              load_pc;
    logic [ADDR_W-1:0] next_pc;
    logic [ID_W-1:0]   cur_id;
    logic              running;
    logic              idle;

    modport master (
        output cfg_we, cfg_sel, cfg_data, proc_load, proc_id, proc_pc,
        output tick, proc_kill, cur_pc, cs_ack,
        input  cs_req, load_pc, next_pc, cur_id, running, idle
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_data, proc_load, proc_id, proc_pc,
        input  tick, proc_kill, cur_pc, cs_ack,
        output cs_req, load_pc, next_pc, cur_id, running, idle
    );
endinterface

// File: rtl/process_scheduler.sv
// Round-robin scheduler: per-slot saved PC table, retired-instruction quantum,
// and the context-switch handshake towards the datapath program counter.
module process_scheduler #(
    parameter int NPROC  = 4,
    parameter int ADDR_W = 12,
    parameter int QW     = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    process_scheduler_if.slave   sched_bus
);
    localparam int ID_W = $clog2(NPROC);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_RUN      = 3'd3,
        ST_SWREQ    = 3'd4
    } state_t;

    // Nearest valid slot after base, wrapping through base itself; MSB = found.
    function automatic logic [ID_W:0] rr_pick(input logic [NPROC-1:0] vld,
                                              input logic [ID_W-1:0]  base);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = {(ID_W+1){1'b0}};
        for (int i = NPROC; i >= 1; i--) begin
            idx = base + ID_W'(i);
            if (vld[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_t            state_r;
    logic [QW-1:0]     quantum_r;
    logic              enable_r;
    logic [QW-1:0]     count_r;
    logic              kill_r;
    logic [NPROC-1:0]  valid_r;
    logic [ADDR_W-1:0] pc_r [NPROC];
    logic [ID_W-1:0]   cur_id_r;
    logic              cs_req_r;
    logic              load_pc_r;
    logic [ADDR_W-1:0] next_pc_r;
    logic              running_r;
    logic              idle_r;

    logic [QW-1:0]     q_eff_s;
    logic [QW:0]       count_plus1_s;
    logic [QW-1:0]     count_inc_s;
    logic              expire_s;
    logic [ID_W:0]     pick_s;
    logic              kill_clr_s;
    logic              save_s;

    // Quantum/expiry arithmetic, slot pick and table write strobes.
    always_comb begin
        q_eff_s       = quantum_r;
        count_plus1_s = {1'b0, count_r} + {{QW{1'b0}}, 1'b1};
        count_inc_s   = count_r;
        kill_clr_s    = 1'b0;
        save_s        = 1'b0;
        pick_s        = rr_pick(valid_r, cur_id_r);

        if (quantum_r == {QW{1'b0}}) begin
            q_eff_s = {{(QW-1){1'b0}}, 1'b1};
        end else begin
            q_eff_s = quantum_r;
        end

        // Saturate rather than wrap so a disabled-then-reenabled run still expires.
        if (count_plus1_s[QW]) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_plus1_s[QW-1:0];
        end

        expire_s = enable_r & sched_bus.tick & (count_plus1_s >= {1'b0, q_eff_s});

        case (state_r)
            ST_RUN: begin
                kill_clr_s = sched_bus.proc_kill;
                save_s     = 1'b0;
            end
            ST_SWREQ: begin
                kill_clr_s = sched_bus.proc_kill;
                if (sched_bus.cs_ack && !kill_r && !sched_bus.proc_kill) begin
                    save_s = 1'b1;
                end else begin
                    save_s = 1'b0;
                end
            end
            default: begin
                kill_clr_s = 1'b0;
                save_s     = 1'b0;
            end
        endcase
    end

    // Configuration registers, writable in any state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quantum_r <= QW'(32'd500000);
            enable_r  <= 1'b0;
        end else if (sched_bus.cfg_we) begin
            if (sched_bus.cfg_sel) begin
                enable_r <= sched_bus.cfg_data[0];
            end else begin
                quantum_r <= sched_bus.cfg_data;
            end
        end
    end

    // Process table: registration, PC save on switch, invalidation on halt.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= {NPROC{1'b0}};
            for (int i = 0; i < NPROC; i++) begin
                pc_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            if (sched_bus.proc_load && !valid_r[sched_bus.proc_id]) begin
                valid_r[sched_bus.proc_id] <= 1'b1;
                pc_r[sched_bus.proc_id]    <= sched_bus.proc_pc;
            end
            if (save_s) begin
                pc_r[cur_id_r] <= sched_bus.cur_pc;
            end
            if (kill_clr_s) begin
                valid_r[cur_id_r] <= 1'b0;
            end
        end
    end

    // Scheduler FSM with registered handshake and status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            count_r   <= {QW{1'b0}};
            kill_r    <= 1'b0;
            cur_id_r  <= ID_W'(NPROC - 1);
            cs_req_r  <= 1'b0;
            load_pc_r <= 1'b0;
            next_pc_r <= {ADDR_W{1'b0}};
            running_r <= 1'b0;
            idle_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable_r && (|valid_r)) begin
                        state_r <= ST_SELECT;
                        idle_r  <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        idle_r  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (pick_s[ID_W]) begin
                        state_r   <= ST_DISPATCH;
                        cur_id_r  <= pick_s[ID_W-1:0];
                        next_pc_r <= pc_r[pick_s[ID_W-1:0]];
                        load_pc_r <= 1'b1;
                        running_r <= 1'b1;
                        count_r   <= {QW{1'b0}};
                    end else begin
                        state_r   <= ST_IDLE;
                        idle_r    <= 1'b1;
                    end
                end
                ST_DISPATCH: begin
                    state_r   <= ST_RUN;
                    load_pc_r <= 1'b0;
                end
                ST_RUN: begin
                    if (sched_bus.proc_kill) begin
                        state_r  <= ST_SWREQ;
                        kill_r   <= 1'b1;
                        cs_req_r <= 1'b1;
                    end else if (expire_s) begin
                        state_r  <= ST_SWREQ;
                        kill_r   <= 1'b0;
                        cs_req_r <= 1'b1;
                        count_r  <= count_inc_s;
                    end else if (enable_r && sched_bus.tick) begin
                        count_r  <= count_inc_s;
                    end else begin
                        count_r  <= count_r;
                    end
                end
                ST_SWREQ: begin
                    if (sched_bus.proc_kill) begin
                        kill_r <= 1'b1;
                    end
                    if (sched_bus.cs_ack) begin
                        state_r   <= ST_SELECT;
                        cs_req_r  <= 1'b0;
                        running_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cs_req_r  <= 1'b0;
                    load_pc_r <= 1'b0;
                    running_r <= 1'b0;
                    idle_r    <= 1'b1;
                end
            endcase
        end
    end

    assign sched_bus.cs_req  = cs_req_r;
    assign sched_bus.load_pc = load_pc_r;
    assign sched_bus.next_pc = next_pc_r;
    assign sched_bus.cur_id  = cur_id_r;
    assign sched_bus.running = running_r;
    assign sched_bus.idle    = idle_r;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: round robin, reselection, halt
// handling, quantum edge cases and mid-switch reset.
module tb_process_scheduler;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    process_scheduler_if #(.NPROC(4), .ADDR_W(12), .QW(32)) sif ();

    process_scheduler #(.NPROC(4), .ADDR_W(12), .QW(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .sched_bus (sif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic init_inputs();
        sif.cfg_we    = 1'b0;
        sif.cfg_sel   = 1'b0;
        sif.cfg_data  = 32'd0;
        sif.proc_load = 1'b0;
        sif.proc_id   = 2'd0;
        sif.proc_pc   = 12'h000;
        sif.tick      = 1'b0;
        sif.proc_kill = 1'b0;
        sif.cur_pc    = 12'h000;
        sif.cs_ack    = 1'b0;
    endtask

    task automatic apply_reset();
        init_inputs();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic cfg_write(input logic sel, input logic [31:0] data);
        sif.cfg_we   = 1'b1;
        sif.cfg_sel  = sel;
        sif.cfg_data = data;
        cyc();
        sif.cfg_we   = 1'b0;
    endtask

    task automatic load_slot(input logic [1:0] id, input logic [11:0] pc);
        sif.proc_load = 1'b1;
        sif.proc_id   = id;
        sif.proc_pc   = pc;
        cyc();
        sif.proc_load = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        sif.tick = 1'b1;
        repeat (n) cyc();
        sif.tick = 1'b0;
    endtask

    task automatic ack(input logic [11:0] pc);
        sif.cur_pc = pc;
        sif.cs_ack = 1'b1;
        cyc();
        sif.cs_ack = 1'b0;
    endtask

    task automatic wait_load(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            found = (sif.load_pc === 1'b1);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (sif.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0h exp=1", sif.idle); end
        checks++; if (sif.cs_req !== 1'b0) begin errors++; $display("FAIL reset_cs_req got=%0h exp=0", sif.cs_req); end
        checks++; if (sif.load_pc !== 1'b0) begin errors++; $display("FAIL reset_load_pc got=%0h exp=0", sif.load_pc); end
        checks++; if (sif.cur_id !== 2'd3) begin errors++; $display("FAIL reset_cur_id got=%0h exp=3", sif.cur_id); end
        checks++; if (sif.running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0h exp=0", sif.running); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        load_slot(2'd0, 12'h100);
        load_slot(2'd2, 12'h200);
        cfg_write(1'b0, 32'd3);
        cfg_write(1'b1, 32'd1);
        cyc();
        checks++; if (sif.load_pc !== 1'b0) begin errors++; $display("FAIL rr_early_load got=%0h exp=0", sif.load_pc); end
        cyc();
        checks++; if (sif.load_pc !== 1'b1) begin errors++; $display("FAIL rr_first_load got=%0h exp=1", sif.load_pc); end
        checks++; if (sif.next_pc !== 12'h100) begin errors++; $display("FAIL rr_first_pc got=%0h exp=100", sif.next_pc); end
        checks++; if (sif.cur_id !== 2'd0) begin errors++; $display("FAIL rr_first_id got=%0h exp=0", sif.cur_id); end
        checks++; if (sif.running !== 1'b1) begin errors++; $display("FAIL rr_running got=%0h exp=1", sif.running); end
        cyc();
        run_ticks(2);
        checks++; if (sif.cs_req !== 1'b0) begin errors++; $display("FAIL rr_no_early_req got=%0h exp=0", sif.cs_req); end
        run_ticks(1);
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL rr_expiry_req got=%0h exp=1", sif.cs_req); end
        repeat (2) cyc();
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL rr_req_held got=%0h exp=1", sif.cs_req); end
        ack(12'h103);
        checks++; if (sif.cs_req !== 1'b0 || sif.load_pc !== 1'b0) begin errors++; $display("FAIL rr_after_ack got=%0h/%0h exp=0/0", sif.cs_req, sif.load_pc); end
        cyc();
        checks++; if (sif.load_pc !== 1'b1 || sif.next_pc !== 12'h200) begin errors++; $display("FAIL rr_second_pc got=%0h/%0h exp=1/200", sif.load_pc, sif.next_pc); end
        checks++; if (sif.cur_id !== 2'd2) begin errors++; $display("FAIL rr_second_id got=%0h exp=2", sif.cur_id); end
        cyc();
        run_ticks(3);
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL rr_second_expiry got=%0h exp=1", sif.cs_req); end
        ack(12'h205);
        cyc();
        checks++; if (sif.load_pc !== 1'b1 || sif.next_pc !== 12'h103) begin errors++; $display("FAIL rr_saved_pc got=%0h/%0h exp=1/103", sif.load_pc, sif.next_pc); end
        checks++; if (sif.cur_id !== 2'd0) begin errors++; $display("FAIL rr_third_id got=%0h exp=0", sif.cur_id); end
        cyc();
        checks++; if (sif.load_pc !== 1'b0) begin errors++; $display("FAIL rr_load_pulse got=%0h exp=0", sif.load_pc); end
    endtask

    task automatic test_single_slot();
        bit found;
        apply_reset();
        load_slot(2'd1, 12'h040);
        cfg_write(1'b0, 32'd2);
        cfg_write(1'b1, 32'd1);
        wait_load(found);
        checks++; if (!found || sif.next_pc !== 12'h040 || sif.cur_id !== 2'd1) begin errors++; $display("FAIL single_first found=%0d pc=%0h id=%0h exp=1/040/1", found, sif.next_pc, sif.cur_id); end
        cyc();
        run_ticks(2);
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL single_expiry got=%0h exp=1", sif.cs_req); end
        ack(12'h042);
        cyc();
        checks++; if (sif.load_pc !== 1'b1 || sif.next_pc !== 12'h042 || sif.cur_id !== 2'd1) begin errors++; $display("FAIL single_reselect got=%0h/%0h/%0h exp=1/042/1", sif.load_pc, sif.next_pc, sif.cur_id); end
    endtask

    task automatic test_kill();
        bit found;
        apply_reset();
        load_slot(2'd0, 12'h100);
        load_slot(2'd2, 12'h200);
        cfg_write(1'b0, 32'd2);
        cfg_write(1'b1, 32'd1);
        wait_load(found);
        checks++; if (!found || sif.next_pc !== 12'h100) begin errors++; $display("FAIL kill_first found=%0d pc=%0h exp=1/100", found, sif.next_pc); end
        cyc();
        run_ticks(1);
        sif.tick      = 1'b1;
        sif.proc_kill = 1'b1;
        cyc();
        sif.tick      = 1'b0;
        sif.proc_kill = 1'b0;
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL kill_req got=%0h exp=1", sif.cs_req); end
        ack(12'h1ff);
        cyc();
        checks++; if (sif.load_pc !== 1'b1 || sif.next_pc !== 12'h200 || sif.cur_id !== 2'd2) begin errors++; $display("FAIL kill_next got=%0h/%0h/%0h exp=1/200/2", sif.load_pc, sif.next_pc, sif.cur_id); end
        cyc();
        run_ticks(2);
        ack(12'h222);
        cyc();
        checks++; if (sif.load_pc !== 1'b1 || sif.next_pc !== 12'h222 || sif.cur_id !== 2'd2) begin errors++; $display("FAIL kill_slot0_gone got=%0h/%0h/%0h exp=1/222/2", sif.load_pc, sif.next_pc, sif.cur_id); end
        cyc();
        run_ticks(2);
        sif.proc_kill = 1'b1;
        cyc();
        sif.proc_kill = 1'b0;
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL kill_swreq_hold got=%0h exp=1", sif.cs_req); end
        ack(12'h2aa);
        cyc();
        checks++; if (sif.idle !== 1'b1 || sif.running !== 1'b0 || sif.load_pc !== 1'b0) begin errors++; $display("FAIL kill_last_idle got=%0h/%0h/%0h exp=1/0/0", sif.idle, sif.running, sif.load_pc); end
    endtask

    task automatic test_quantum();
        bit found;
        bit saw_req;
        apply_reset();
        load_slot(2'd3, 12'h030);
        cfg_write(1'b0, 32'd2);
        cfg_write(1'b1, 32'd1);
        wait_load(found);
        checks++; if (!found || sif.next_pc !== 12'h030 || sif.cur_id !== 2'd3) begin errors++; $display("FAIL q_first found=%0d pc=%0h id=%0h exp=1/030/3", found, sif.next_pc, sif.cur_id); end
        cyc();
        saw_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (sif.cs_req === 1'b1) saw_req = 1'b1;
        end
        checks++; if (saw_req) begin errors++; $display("FAIL q_stall_no_req got=1 exp=0"); end
        run_ticks(1);
        cyc();
        cfg_write(1'b0, 32'd1);
        checks++; if (sif.cs_req !== 1'b0) begin errors++; $display("FAIL q_lower_no_req got=%0h exp=0", sif.cs_req); end
        run_ticks(1);
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL q_lower_req got=%0h exp=1", sif.cs_req); end
        ack(12'h031);
        cyc();
        checks++; if (sif.load_pc !== 1'b1 || sif.next_pc !== 12'h031) begin errors++; $display("FAIL q_reselect got=%0h/%0h exp=1/031", sif.load_pc, sif.next_pc); end
        cyc();
        cfg_write(1'b0, 32'd0);
        run_ticks(1);
        checks++; if (sif.cs_req !== 1'b1) begin errors++; $display("FAIL q_zero_as_one got=%0h exp=1", sif.cs_req); end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit bad;
        reset = 1'b0;
        #2;
        checks++; if (sif.cs_req !== 1'b0 || sif.idle !== 1'b1 || sif.running !== 1'b0) begin errors++; $display("FAIL rst_async got=%0h/%0h/%0h exp=0/1/0", sif.cs_req, sif.idle, sif.running); end
        checks++; if (sif.cur_id !== 2'd3) begin errors++; $display("FAIL rst_cur_id got=%0h exp=3", sif.cur_id); end
        init_inputs();
        cyc();
        reset = 1'b1;
        cfg_write(1'b1, 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (sif.load_pc === 1'b1 || sif.idle !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL rst_table_clear got=dispatch exp=idle"); end
        load_slot(2'd3, 12'h077);
        wait_load(found);
        checks++; if (!found || sif.next_pc !== 12'h077 || sif.cur_id !== 2'd3) begin errors++; $display("FAIL rst_reload found=%0d pc=%0h id=%0h exp=1/077/3", found, sif.next_pc, sif.cur_id); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        init_inputs();
        test_reset();
        test_round_robin();
        test_single_slot();
        test_kill();
        test_quantum();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
